// File: rtl/udiv_pkg.sv
// Shared definitions for the 16/8 unsigned sequential divider.
package udiv_pkg;

  localparam int unsigned DIVIDEND_W = 16;
  localparam int unsigned DIVISOR_W  = 8;
  // Partial remainder carries one extra bit so the shifted value never overflows.
  localparam int unsigned REM_W      = DIVISOR_W + 1;

  localparam logic [DIVIDEND_W-1:0] DZ_QUOTIENT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } udiv_state_e;

  // Number of BUSY cycles needed to retire every dividend bit.
  function automatic int unsigned busy_cycles(input int unsigned iter);
    return DIVIDEND_W / iter;
  endfunction

endpackage

// File: rtl/udiv_step.sv
// One radix-2 restoring division step: shift in a dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module udiv_step
  import udiv_pkg::*;
(
  input  logic [REM_W-1:0]     i_rem,
  input  logic                 i_bit,
  input  logic [DIVISOR_W-1:0] i_y,
  output logic [REM_W-1:0]     o_rem,
  output logic                 o_qbit
);

  logic [REM_W-1:0] w_shift;
  logic [REM_W-1:0] w_diff;
  logic             w_ge;

  // Incoming remainder is always < y, so its MSB is zero and the shift is lossless.
  assign w_shift = {i_rem[REM_W-2:0], i_bit};
  assign w_ge    = (w_shift >= {1'b0, i_y});
  assign w_diff  = w_shift - {1'b0, i_y};
  assign o_rem   = w_ge ? w_diff : w_shift;
  assign o_qbit  = w_ge;

endmodule

// File: rtl/unsigned_seq_divider_16x8.sv
// Unsigned 16-bit by 8-bit sequential restoring divider with valid/ready
// handshakes on both sides. ITER_PER_CYCLE (1, 2, 4 or 8) steps per clock.
// Optional remainder output is enabled by defining UDIV_REMAINDER_EN.
module unsigned_seq_divider_16x8
  import udiv_pkg::*;
#(
  parameter int unsigned ITER_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] x,
  input  logic [DIVISOR_W-1:0]  y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] q,
`ifdef UDIV_REMAINDER_EN
  output logic [DIVISOR_W-1:0]  r,
`endif
  output logic                  dz
);

  localparam int unsigned NumCycles = busy_cycles(ITER_PER_CYCLE);
  localparam logic [3:0]  LastCnt   = 4'(NumCycles - 1);

  udiv_state_e r_state, w_state_next;

  logic [DIVIDEND_W-1:0] r_dvd;  // dividend bits shift out the top, quotient bits in the bottom
  logic [DIVISOR_W-1:0]  r_div;
  logic [REM_W-1:0]      r_rem;
  logic [3:0]            r_cnt;
  logic [DIVIDEND_W-1:0] r_q;
  logic                  r_dz;
`ifdef UDIV_REMAINDER_EN
  logic [DIVISOR_W-1:0]  r_r;
`endif

  logic [ITER_PER_CYCLE:0][REM_W-1:0] w_rem_chain;
  logic [ITER_PER_CYCLE-1:0]          w_qbits;
  logic [DIVIDEND_W-1:0]              w_dvd_next;
  logic                               w_last;

  assign w_rem_chain[0] = r_rem;

  for (genvar g = 0; g < ITER_PER_CYCLE; g++) begin : g_step
    udiv_step u_step (
      .i_rem  (w_rem_chain[g]),
      .i_bit  (r_dvd[DIVIDEND_W-1-g]),
      .i_y    (r_div),
      .o_rem  (w_rem_chain[g+1]),
      .o_qbit (w_qbits[ITER_PER_CYCLE-1-g])
    );
  end

  assign w_dvd_next = {r_dvd[DIVIDEND_W-ITER_PER_CYCLE-1:0], w_qbits};
  assign w_last     = (r_cnt == LastCnt);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = (y == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd <= '0;
      r_div <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_dz  <= 1'b0;
`ifdef UDIV_REMAINDER_EN
      r_r   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (y == '0) begin
              // Divide by zero: result is produced immediately, no iteration.
              r_q  <= DZ_QUOTIENT;
              r_dz <= 1'b1;
`ifdef UDIV_REMAINDER_EN
              r_r  <= x[DIVISOR_W-1:0];
`endif
            end else begin
              r_dvd <= x;
              r_div <= y;
              r_rem <= '0;
              r_cnt <= '0;
            end
          end
        end
        BUSY: begin
          r_dvd <= w_dvd_next;
          r_rem <= w_rem_chain[ITER_PER_CYCLE];
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_q  <= w_dvd_next;
            r_dz <= 1'b0;
`ifdef UDIV_REMAINDER_EN
            r_r  <= w_rem_chain[ITER_PER_CYCLE][DIVISOR_W-1:0];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign q  = r_q;
  assign dz = r_dz;
`ifdef UDIV_REMAINDER_EN
  assign r  = r_r;
`endif

endmodule
